// File: rtl/fsm_par_join_pkg.sv
// -----------------------------------------------------------------------------
// fsm_par_join_pkg
// Shared controller package. Holds the state types for the parallel-join
// controller (fsm_par_join) and the sequential controller, plus small helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package fsm_par_join_pkg;

  // Upper bound on the number of parallel child groups a join may span.
  localparam int unsigned N_CHILD_MAX = 16;

  // Parallel-join controller states. Encoding 2'b11 is unreachable and
  // decodes to IDLE behaviour.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } par_join_state_e;

  // Sequential controller states, kept here so both controllers share one
  // package.
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_STEP = 2'd1,
    SEQ_WAIT = 2'd2,
    SEQ_DONE = 2'd3
  } seq_state_e;

  // True for the three encodings the join controller can actually reach.
  function automatic logic pj_state_legal(input par_join_state_e s);
    return (s == IDLE) || (s == RUN) || (s == DONE);
  endfunction

endpackage

// File: rtl/fsm_par_join_if.sv
// -----------------------------------------------------------------------------
// fsm_par_join_if
// Handshake bundle between a parent, the join controller and its children.
//   valid        parent go (parent -> controller)
//   ready        parent done, one-cycle pulse (controller -> parent)
//   valid_child  per-child go (controller -> children), N_CHILD bits
//   ready_child  per-child done, pulse or level (children -> controller)
// Handshake semantics: the parent raises valid to request a join; the
// controller only looks at valid while idle, so valid may drop once the join
// has started. Each child i is driven while valid_child[i] is high and reports
// completion by raising ready_child[i] for at least one cycle; the controller
// records that completion and drops valid_child[i] on the following cycle.
// When every child has reported, ready pulses for exactly one cycle.
// Modports: master = parent/children side, slave = controller side.
// -----------------------------------------------------------------------------
interface fsm_par_join_if #(
  parameter int N_CHILD = 3
);
  logic               valid;
  logic               ready;
  logic [N_CHILD-1:0] valid_child;
  logic [N_CHILD-1:0] ready_child;

  modport master (
    output valid,
    output ready_child,
    input  ready,
    input  valid_child
  );

  modport slave (
    input  valid,
    input  ready_child,
    output ready,
    output valid_child
  );
endinterface

// File: rtl/fsm_par_join.sv
// -----------------------------------------------------------------------------
// fsm_par_join
// Fork/join controller: on a parent valid it drives all N_CHILD children,
// records each child's completion in a sticky done mask, and pulses ready once
// every child has completed.
// Ports:
//   clk      sole clock, rising edge
//   reset    synchronous, active-high
//   bus      fsm_par_join_if.slave (valid, ready, valid_child, ready_child)
//   state_o  current controller state, for observation
// Parameter N_CHILD: number of children, legal range 1..16.
// -----------------------------------------------------------------------------
module fsm_par_join
  import fsm_par_join_pkg::*;
#(
  parameter int N_CHILD = 3
) (
  input  logic                clk,
  input  logic                reset,
  fsm_par_join_if.slave       bus,
  output par_join_state_e     state_o
);

  par_join_state_e    state_q, state_d;
  logic [N_CHILD-1:0] mask_q, mask_d;
  logic [N_CHILD-1:0] mask_join;
  logic               ready_int;
  logic [N_CHILD-1:0] valid_child_int;

  // Completions seen so far plus those arriving this cycle; the join is
  // judged on this so the last child's ready is honoured in its own cycle.
  assign mask_join = mask_q | bus.ready_child;

  // State register and done mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Next-state and next-mask logic. The mask only accumulates in RUN, so
  // stray child completions in IDLE or DONE are dropped.
  always_comb begin
    state_d = IDLE;
    mask_d  = '0;
    case (state_q)
      IDLE: begin
        if (bus.valid) state_d = RUN;
      end
      RUN: begin
        if (&mask_join) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          mask_d  = mask_join;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore output decode from state and mask only.
  always_comb begin
    ready_int       = 1'b0;
    valid_child_int = '0;
    case (state_q)
      IDLE: begin
        ready_int       = 1'b0;
        valid_child_int = '0;
      end
      RUN: begin
        ready_int       = 1'b0;
        valid_child_int = ~mask_q;
      end
      DONE: begin
        ready_int       = 1'b1;
        valid_child_int = '0;
      end
      default: begin
        ready_int       = 1'b0;
        valid_child_int = '0;
      end
    endcase
  end

  assign bus.ready       = ready_int;
  assign bus.valid_child = valid_child_int;
  assign state_o         = state_q;

endmodule

// File: tb/tb_fsm_par_join.sv
// -----------------------------------------------------------------------------
// tb_fsm_par_join
// Directed bench for fsm_par_join: a 3-child instance and a 1-child instance
// share clock and reset. Each cycle task checks the Moore outputs of the cycle
// just started, then drives that cycle's inputs.
// -----------------------------------------------------------------------------
module tb_fsm_par_join;
  import fsm_par_join_pkg::*;

  logic clk;
  logic reset;
  par_join_state_e st3, st1;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  fsm_par_join_if #(.N_CHILD(3)) if3 ();
  fsm_par_join_if #(.N_CHILD(1)) if1 ();

  fsm_par_join #(.N_CHILD(3)) u_dut3 (
    .clk     (clk),
    .reset   (reset),
    .bus     (if3),
    .state_o (st3)
  );

  fsm_par_join #(.N_CHILD(1)) u_dut1 (
    .clk     (clk),
    .reset   (reset),
    .bus     (if1),
    .state_o (st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard check
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: 3-child instance
  task automatic cyc3(input logic v, input logic [2:0] rc,
                      input logic exp_r, input logic [2:0] exp_vc, input string tag);
    @(posedge clk); #1;
    exp_q.push_back({4'b0, exp_r, exp_vc});
    check(tag, {4'b0, if3.ready, if3.valid_child}, exp_q.pop_front());
    if3.valid       = v;
    if3.ready_child = rc;
  endtask

  // driver: 1-child instance
  task automatic cyc1(input logic v, input logic rc,
                      input logic exp_r, input logic exp_vc, input string tag);
    @(posedge clk); #1;
    exp_q.push_back({6'b0, exp_r, exp_vc});
    check(tag, {6'b0, if1.ready, if1.valid_child}, exp_q.pop_front());
    if1.valid       = v;
    if1.ready_child = rc;
  endtask

  initial begin
    reset           = 1'b1;
    if3.valid       = 1'b0;
    if3.ready_child = '0;
    if1.valid       = 1'b0;
    if1.ready_child = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out3", {4'b0, if3.ready, if3.valid_child}, 8'h00);
    check("rst_st3", 8'(st3), 8'(IDLE));
    check("rst_out1", {6'b0, if1.ready, if1.valid_child}, 8'h00);
    check("rst_st1", 8'(st1), 8'(IDLE));
    reset = 1'b0;

    // simultaneous join
    cyc3(1, 3'b000, 0, 3'b000, "sim_c0");
    cyc3(0, 3'b111, 0, 3'b111, "sim_c1");
    cyc3(0, 3'b000, 1, 3'b000, "sim_c2");
    cyc3(0, 3'b000, 0, 3'b000, "sim_c3");
    cyc3(0, 3'b000, 0, 3'b000, "sim_c4");

    // staggered join, valid dropped during RUN
    cyc3(1, 3'b000, 0, 3'b000, "stg_c0");
    cyc3(0, 3'b001, 0, 3'b111, "stg_c1");
    cyc3(0, 3'b000, 0, 3'b110, "stg_c2");
    cyc3(0, 3'b100, 0, 3'b110, "stg_c3");
    cyc3(0, 3'b000, 0, 3'b010, "stg_c4");
    cyc3(0, 3'b010, 0, 3'b010, "stg_c5");
    cyc3(0, 3'b000, 1, 3'b000, "stg_c6");
    cyc3(0, 3'b000, 0, 3'b000, "stg_c7");

    // stray ready while IDLE, duplicate ready on child 0
    for (int i = 0; i < 3; i++) cyc3(0, 3'b111, 0, 3'b000, "stray_idle");
    #1 check("stray_st", 8'(st3), 8'(IDLE));
    cyc3(1, 3'b001, 0, 3'b000, "dup_c0");
    cyc3(0, 3'b001, 0, 3'b111, "dup_c1");
    cyc3(0, 3'b001, 0, 3'b110, "dup_c2");
    cyc3(0, 3'b101, 0, 3'b110, "dup_c3");
    cyc3(0, 3'b001, 0, 3'b010, "dup_c4");
    cyc3(0, 3'b011, 0, 3'b010, "dup_c5");
    cyc3(0, 3'b001, 1, 3'b000, "dup_c6");
    cyc3(0, 3'b001, 0, 3'b000, "dup_c7");
    cyc3(0, 3'b000, 0, 3'b000, "dup_c8");

    // reset mid-RUN after child 0 done
    cyc3(1, 3'b000, 0, 3'b000, "rmid_c0");
    cyc3(0, 3'b001, 0, 3'b111, "rmid_c1");
    cyc3(0, 3'b000, 0, 3'b110, "rmid_c2");
    reset = 1'b1;
    cyc3(0, 3'b000, 0, 3'b000, "rmid_c3");
    reset = 1'b0;
    cyc3(0, 3'b000, 0, 3'b000, "rmid_c4");
    cyc3(1, 3'b000, 0, 3'b000, "rmid_c5");
    cyc3(0, 3'b110, 0, 3'b111, "rmid_c6");
    cyc3(0, 3'b000, 0, 3'b001, "rmid_c7");
    cyc3(0, 3'b001, 0, 3'b001, "rmid_c8");
    cyc3(0, 3'b000, 1, 3'b000, "rmid_c9");
    cyc3(0, 3'b000, 0, 3'b000, "rmid_c10");

    // reset in the cycle the join completes: no ready pulse
    cyc3(1, 3'b000, 0, 3'b000, "rjn_c0");
    cyc3(0, 3'b111, 0, 3'b111, "rjn_c1");
    reset = 1'b1;
    cyc3(0, 3'b000, 0, 3'b000, "rjn_c2");
    reset = 1'b0;
    cyc3(0, 3'b000, 0, 3'b000, "rjn_c3");

    // long hold in RUN with child 2 outstanding
    cyc3(1, 3'b000, 0, 3'b000, "hold_c0");
    cyc3(0, 3'b011, 0, 3'b111, "hold_c1");
    for (int i = 0; i < 20; i++) cyc3(0, 3'b000, 0, 3'b100, "hold_run");
    #1 check("hold_st", 8'(st3), 8'(RUN));
    cyc3(0, 3'b100, 0, 3'b100, "hold_last");
    cyc3(0, 3'b000, 1, 3'b000, "hold_done");
    cyc3(0, 3'b000, 0, 3'b000, "hold_idle");

    // back-to-back joins with valid held high
    for (int k = 0; k < 3; k++) begin
      cyc3(1, 3'b111, 0, 3'b000, "b2b_idle");
      cyc3(1, 3'b111, 0, 3'b111, "b2b_run");
      cyc3(1, 3'b111, 1, 3'b000, "b2b_done");
    end
    cyc3(0, 3'b000, 0, 3'b000, "b2b_end0");
    cyc3(0, 3'b000, 0, 3'b000, "b2b_end1");

    // single-child build
    cyc1(1, 1'b0, 0, 1'b0, "one_c0");
    cyc1(0, 1'b1, 0, 1'b1, "one_c1");
    cyc1(0, 1'b0, 1, 1'b0, "one_c2");
    cyc1(0, 1'b0, 0, 1'b0, "one_c3");
    cyc1(1, 1'b0, 0, 1'b0, "one_s0");
    cyc1(0, 1'b0, 0, 1'b1, "one_s1");
    cyc1(0, 1'b1, 0, 1'b1, "one_s2");
    cyc1(0, 1'b0, 1, 1'b0, "one_s3");
    cyc1(0, 1'b0, 0, 1'b0, "one_s4");

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
